// File: rtl/wb_pwmaudio_feeder.sv
// wb_pwmaudio_feeder: CPU-filled 16-bit sample FIFO that writes one sample to the PWM audio
// device per "need sample" request. Optional bus watchdog: WB_PWMAUDIO_FEEDER_TIMEOUT_EN.
module wb_pwmaudio_feeder #(
   parameter int LGFIFO    = 5,
   parameter int LOW_WATER = 8,
   parameter int NAUX      = 2
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_wb_cyc,
   input  logic        i_wb_stb,
   input  logic        i_wb_we,
   input  logic        i_wb_addr,
   input  logic [31:0] i_wb_data,
   output logic        o_wb_ack,
   output logic        o_wb_stall,
   output logic [31:0] o_wb_data,
   output logic        o_aud_cyc,
   output logic        o_aud_stb,
   output logic        o_aud_we,
   output logic        o_aud_addr,
   output logic [31:0] o_aud_data,
   input  logic        i_aud_ack,
   input  logic        i_aud_stall,
   input  logic        i_aud_int,
   output logic        o_int
);

   localparam int                DEPTH       = 1 << LGFIFO;
   localparam logic [31:0]       LOW_WATER_U = 32'(LOW_WATER);
   localparam logic [LGFIFO-1:0] PTR_ONE     = {{(LGFIFO-1){1'b0}}, 1'b1};
   localparam logic [LGFIFO:0]   FILL_ONE    = {{LGFIFO{1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2
   } state_t;

   logic [15:0]       mem_r [0:DEPTH-1];
   logic [LGFIFO-1:0] wr_ptr_r, rd_ptr_r;
   logic [LGFIFO:0]   fill_r;
   logic              enable_r, silence_r, overflow_r, aux_pending_r, int_prev_r;
   logic [NAUX-1:0]   aux_r;
   logic [7:0]        underrun_r;
   state_t            state_r, state_nx_s;
   logic              aud_cyc_r, aud_stb_r, aud_we_r, cyc_nx_s, stb_nx_s;
   logic [31:0]       aud_data_r, wb_data_r;
   logic              wb_ack_r;
   logic              wr_s, fifo_wr_s, ctrl_wr_s, flush_s, clear_s, push_s, pop_s;
   logic              empty_s, full_s, start_s, accept_s, timeout_s, err_s;
   logic [15:0]       sample_s;
   logic [31:0]       word_s, status_s, fill_word_s;
   logic              unused_s;

   assign wr_s      = i_wb_cyc & i_wb_stb & i_wb_we;
   assign fifo_wr_s = wr_s & ~i_wb_addr;
   assign ctrl_wr_s = wr_s & i_wb_addr;
   assign flush_s   = ctrl_wr_s & i_wb_data[1];
   assign clear_s   = ctrl_wr_s & i_wb_data[2];
   assign empty_s   = (fill_r == {(LGFIFO+1){1'b0}});
   assign full_s    = fill_r[LGFIFO];
   assign start_s   = (state_r == ST_IDLE) & enable_r & i_aud_int & (~empty_s | silence_r);
   assign push_s    = fifo_wr_s & ~full_s & ~flush_s;
   assign pop_s     = start_s & ~empty_s;
   assign accept_s  = (state_r == ST_REQ) & ~i_aud_stall & ~timeout_s;
   assign unused_s  = ^{i_wb_data[31:NAUX+20], i_wb_data[19:17]};

   assign o_wb_ack   = wb_ack_r;
   assign o_wb_stall = 1'b0;
   assign o_wb_data  = wb_data_r;
   assign o_aud_cyc  = aud_cyc_r;
   assign o_aud_stb  = aud_stb_r;
   assign o_aud_we   = aud_we_r;
   assign o_aud_addr = 1'b0;
   assign o_aud_data = aud_data_r;
   assign o_int      = enable_r & ({{(31-LGFIFO){1'b0}}, fill_r} <= LOW_WATER_U);

`ifdef WB_PWMAUDIO_FEEDER_TIMEOUT_EN
   logic [7:0] wdog_r;
   logic       err_r;

   assign timeout_s = (wdog_r == 8'd255) &
                      ((state_r == ST_REQ) | ((state_r == ST_WAIT) & ~i_aud_ack));
   assign err_s     = err_r;

   // Watchdog on a stuck device transaction, with sticky error flag
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wdog_r <= 8'd0;
         err_r  <= 1'b0;
      end else begin
         if (start_s) begin
            wdog_r <= 8'd0;
         end else if ((state_r != ST_IDLE) && (wdog_r != 8'd255)) begin
            wdog_r <= wdog_r + 8'd1;
         end
         if (timeout_s) begin
            err_r <= 1'b1;
         end else if (clear_s) begin
            err_r <= 1'b0;
         end
      end
   end
`else
   assign timeout_s = 1'b0;
   assign err_s     = 1'b0;
`endif

   // Sample selection, outgoing device word and status/fill read words
   always_comb begin
      sample_s    = empty_s ? 16'h0000 : mem_r[rd_ptr_r];
      word_s      = 32'd0;
      word_s[NAUX+19:20] = aux_r;
      word_s[16]         = aux_pending_r;
      word_s[15:0]       = sample_s;
      fill_word_s = 32'd0;
      fill_word_s[LGFIFO:0] = fill_r;
      status_s    = 32'd0;
      status_s[31:24]       = underrun_r;
      status_s[NAUX+19:20]  = aux_r;
      status_s[16]          = aux_pending_r;
      status_s[LGFIFO+8:8]  = fill_r;
      status_s[7]           = err_s;
      status_s[6]           = (state_r != ST_IDLE);
      status_s[5]           = full_s;
      status_s[4]           = empty_s;
      status_s[3]           = silence_r;
      status_s[2]           = overflow_r;
      status_s[0]           = enable_r;
   end

   // Master sequencer next state; acceptance drops stb, ack drops cyc
   always_comb begin
      state_nx_s = state_r;
      cyc_nx_s   = aud_cyc_r;
      stb_nx_s   = aud_stb_r;
      case (state_r)
         ST_IDLE: begin
            if (start_s) begin
               state_nx_s = ST_REQ;
               cyc_nx_s   = 1'b1;
               stb_nx_s   = 1'b1;
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_REQ: begin
            if (timeout_s) begin
               state_nx_s = ST_IDLE;
               cyc_nx_s   = 1'b0;
               stb_nx_s   = 1'b0;
            end else if (!i_aud_stall) begin
               state_nx_s = ST_WAIT;
               stb_nx_s   = 1'b0;
            end else begin
               state_nx_s = ST_REQ;
            end
         end
         ST_WAIT: begin
            if (i_aud_ack || timeout_s) begin
               state_nx_s = ST_IDLE;
               cyc_nx_s   = 1'b0;
               stb_nx_s   = 1'b0;
            end else begin
               state_nx_s = ST_WAIT;
            end
         end
         default: begin
            state_nx_s = ST_IDLE;
            cyc_nx_s   = 1'b0;
            stb_nx_s   = 1'b0;
         end
      endcase
   end

   // Sample storage (contents need no reset; fill/pointers qualify them)
   always_ff @(posedge i_clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= i_wb_data[15:0];
      end
   end

   // FIFO pointers and fill level; flush beats any push
   always_ff @(posedge i_clk) begin
      if (i_rst || flush_s) begin
         wr_ptr_r <= {LGFIFO{1'b0}};
         rd_ptr_r <= {LGFIFO{1'b0}};
         fill_r   <= {(LGFIFO+1){1'b0}};
      end else begin
         if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
         if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
         if (push_s && !pop_s) begin
            fill_r <= fill_r + FILL_ONE;
         end else if (!push_s && pop_s) begin
            fill_r <= fill_r - FILL_ONE;
         end
      end
   end

   // Control/status registers and the underrun counter
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         enable_r      <= 1'b0;
         silence_r     <= 1'b0;
         aux_r         <= {NAUX{1'b0}};
         aux_pending_r <= 1'b0;
         overflow_r    <= 1'b0;
         underrun_r    <= 8'd0;
         int_prev_r    <= 1'b0;
      end else begin
         int_prev_r <= i_aud_int;
         if (ctrl_wr_s) begin
            enable_r  <= i_wb_data[0];
            silence_r <= i_wb_data[3];
            aux_r     <= i_wb_data[NAUX+19:20];
         end
         if (ctrl_wr_s && i_wb_data[16]) begin
            aux_pending_r <= 1'b1;
         end else if (accept_s && aud_data_r[16]) begin
            aux_pending_r <= 1'b0;
         end
         if (clear_s) begin
            overflow_r <= 1'b0;
         end else if (fifo_wr_s && full_s && !flush_s) begin
            overflow_r <= 1'b1;
         end
         if (clear_s) begin
            underrun_r <= 8'd0;
         end else if (i_aud_int && !int_prev_r && enable_r && empty_s && (underrun_r != 8'd255)) begin
            underrun_r <= underrun_r + 8'd1;
         end
      end
   end

   // Registered bus outputs and sequencer state
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wb_ack_r   <= 1'b0;
         wb_data_r  <= 32'd0;
         state_r    <= ST_IDLE;
         aud_cyc_r  <= 1'b0;
         aud_stb_r  <= 1'b0;
         aud_we_r   <= 1'b0;
         aud_data_r <= 32'd0;
      end else begin
         wb_ack_r  <= i_wb_stb;
         wb_data_r <= i_wb_addr ? status_s : fill_word_s;
         state_r   <= state_nx_s;
         aud_cyc_r <= cyc_nx_s;
         aud_stb_r <= stb_nx_s;
         aud_we_r  <= 1'b1;
         if (start_s) begin
            aud_data_r <= word_s;
         end
      end
   end

endmodule

// File: tb/tb_wb_pwmaudio_feeder.sv
// Bench for wb_pwmaudio_feeder: directed scenarios plus a randomized push/request phase,
// with a behavioural audio-device responder and an in-order sample scoreboard.
module tb_wb_pwmaudio_feeder;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic        i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr;
   logic [31:0] i_wb_data;
   logic        o_wb_ack, o_wb_stall;
   logic [31:0] o_wb_data;
   logic        o_aud_cyc, o_aud_stb, o_aud_we, o_aud_addr;
   logic [31:0] o_aud_data;
   logic        i_aud_ack, i_aud_stall, i_aud_int;
   logic        o_int;

   int total = 0;
   int bad   = 0;

   // device-side state (owned by the responder process)
   logic [31:0] rx_q[$];
   logic [31:0] last_word = 32'd0;
   logic [31:0] first_word = 32'd0;
   int  acc_cnt = 0, last_stb = 0, last_unstable = 0;
   int  stb_run = 0, stall_run = 0, unstable = 0, ack_dly = 0;
   bit  in_wait = 1'b0, auto_pend = 1'b0;
   // scenario knobs (owned by the main process)
   bit  man_int = 1'b0, auto_int = 1'b0, rand_mode = 1'b0, no_ack = 1'b0;
   int  stall_len = 0;

   wb_pwmaudio_feeder #(.LGFIFO(5), .LOW_WATER(8), .NAUX(2)) dut (
      .i_clk(i_clk), .i_rst(i_rst),
      .i_wb_cyc(i_wb_cyc), .i_wb_stb(i_wb_stb), .i_wb_we(i_wb_we),
      .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data),
      .o_wb_ack(o_wb_ack), .o_wb_stall(o_wb_stall), .o_wb_data(o_wb_data),
      .o_aud_cyc(o_aud_cyc), .o_aud_stb(o_aud_stb), .o_aud_we(o_aud_we),
      .o_aud_addr(o_aud_addr), .o_aud_data(o_aud_data),
      .i_aud_ack(i_aud_ack), .i_aud_stall(i_aud_stall), .i_aud_int(i_aud_int),
      .o_int(o_int)
   );

   always #5 i_clk = ~i_clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
      end
   endtask

   task automatic wb_write(input logic a, input logic [31:0] d);
      @(posedge i_clk); #1;
      i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b1; i_wb_addr = a; i_wb_data = d;
      @(posedge i_clk); #1;
      i_wb_cyc = 1'b0; i_wb_stb = 1'b0; i_wb_we = 1'b0;
   endtask

   task automatic wb_read(input logic a, output logic [31:0] d);
      @(posedge i_clk); #1;
      i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b0; i_wb_addr = a;
      @(posedge i_clk); #1;
      d = o_wb_data;
      check_val("wb_ack", {31'd0, o_wb_ack}, 32'd1);
      i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
   endtask

   task automatic pulse();
      @(posedge i_clk); #1; man_int = 1'b1;
      @(posedge i_clk); #1; man_int = 1'b0;
   endtask

   task automatic pulse_wait(input string tag, input logic [31:0] exp);
      int n0;
      n0 = acc_cnt;
      pulse();
      for (int i = 0; i < 60; i++) begin
         if (acc_cnt == n0 + 1 && !o_aud_cyc) break;
         @(posedge i_clk); #1;
      end
      check_val({tag, "_cnt"}, acc_cnt, n0 + 1);
      check_val(tag, last_word, exp);
   endtask

   // Behavioural audio device: stalls, accepts, acks and raises its request line
   initial begin
      bit stall;
      i_aud_int = 1'b0; i_aud_stall = 1'b0; i_aud_ack = 1'b0;
      forever begin
         @(posedge i_clk); #2;
         i_aud_ack = 1'b0;
         if (i_rst || !o_aud_cyc) begin
            in_wait = 1'b0;
         end else if (in_wait && !no_ack) begin
            if (ack_dly == 0) begin
               i_aud_ack = 1'b1;
               in_wait   = 1'b0;
            end else begin
               ack_dly--;
            end
         end
         if (o_aud_stb && !i_rst) begin
            if (stb_run == 0) first_word = o_aud_data;
            else if (o_aud_data !== first_word) unstable++;
            stb_run++;
            stall = rand_mode ? ($urandom_range(0, 3) == 0) : (stall_run < stall_len);
            i_aud_stall = stall;
            if (stall) begin
               stall_run++;
            end else begin
               rx_q.push_back(o_aud_data);
               last_word     = o_aud_data;
               acc_cnt++;
               last_stb      = stb_run;
               last_unstable = unstable;
               stb_run = 0; stall_run = 0; unstable = 0;
               in_wait   = 1'b1;
               ack_dly   = rand_mode ? int'($urandom_range(0, 3)) : 0;
               auto_pend = 1'b0;
            end
         end else begin
            i_aud_stall = rand_mode ? 1'($urandom_range(0, 1)) : 1'b0;
            stb_run = 0; stall_run = 0; unstable = 0;
         end
         if (auto_int) begin
            if (!auto_pend && $urandom_range(0, 7) == 0) auto_pend = 1'b1;
            i_aud_int = auto_pend;
         end else begin
            auto_pend = 1'b0;
            i_aud_int = man_int;
         end
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [31:0] rd;
      logic [31:0] sent_q[$];
      logic [15:0] s;
      int n0, rx_base, cnt;
      i_rst = 1'b1; i_wb_cyc = 1'b0; i_wb_stb = 1'b0; i_wb_we = 1'b0;
      i_wb_addr = 1'b0; i_wb_data = 32'd0;
      repeat (3) @(posedge i_clk);
      #1;
      check_val("reset_outs", {o_wb_ack, o_wb_stall, o_aud_cyc, o_aud_stb, o_aud_we, o_aud_addr, o_int},
                32'd0);
      check_val("reset_data", o_aud_data | o_wb_data, 32'd0);
      i_rst = 1'b0;
      wb_read(1'b1, rd);  check_val("reset_status", rd, 32'h0000_0010);
      @(posedge i_clk); #1;
      check_val("ack_drop", {31'd0, o_wb_ack}, 32'd0);
      check_val("aud_we", {31'd0, o_aud_we}, 32'd1);

      // basic transfer
      wb_write(1'b1, 32'h1);
      wb_write(1'b0, 32'hABCD_1234);
      check_val("int_low_fill", {31'd0, o_int}, 32'd1);
      pulse_wait("basic_word", 32'h0000_1234);
      check_val("basic_stb_len", last_stb, 32'd1);
      wb_read(1'b0, rd);  check_val("basic_fill", rd, 32'd0);

      // overflow and low-water interrupt
      wb_write(1'b1, 32'h0);
      for (int i = 0; i < 40; i++) wb_write(1'b0, 32'h100 + i);
      wb_read(1'b1, rd);  check_val("ovf_status", rd, 32'h0000_2024);
      wb_write(1'b1, 32'h1);
      check_val("ovf_int_off", {31'd0, o_int}, 32'd0);
      wb_read(1'b1, rd);  check_val("ovf_status_en", rd, 32'h0000_2025);
      for (int i = 0; i < 23; i++) pulse_wait("drain_word", 32'h100 + i);
      check_val("int_fill9", {31'd0, o_int}, 32'd0);
      pulse_wait("drain_word", 32'h117);
      check_val("int_fill8", {31'd0, o_int}, 32'd1);
      for (int i = 24; i < 32; i++) pulse_wait("drain_word", 32'h100 + i);
      wb_read(1'b0, rd);  check_val("drain_fill", rd, 32'd0);

      // underrun, then silence
      wb_write(1'b1, 32'h5);
      n0 = acc_cnt;
      pulse(); repeat (3) @(posedge i_clk);
      pulse(); repeat (5) @(posedge i_clk);
      #1;
      check_val("underrun_nowrite", acc_cnt, n0);
      wb_read(1'b1, rd);  check_val("underrun_status", rd, 32'h0200_0011);
      wb_write(1'b1, 32'h9);
      pulse_wait("silence_word", 32'h0000_0000);
      wb_read(1'b1, rd);  check_val("silence_status", rd, 32'h0300_0019);

      // aux bits and one-shot aux_pending
      wb_write(1'b1, 32'h0021_0001);
      wb_write(1'b0, 32'h42);
      wb_write(1'b0, 32'h43);
      pulse_wait("aux_word1", 32'h0021_0042);
      pulse_wait("aux_word2", 32'h0020_0043);
      wb_read(1'b1, rd);  check_val("aux_status", rd, 32'h0320_0011);

      // device stall, with push coinciding with pop
      wb_write(1'b0, 32'h777);
      stall_len = 4;
      n0 = acc_cnt;
      @(posedge i_clk); #1;
      man_int = 1'b1;
      i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b1; i_wb_addr = 1'b0; i_wb_data = 32'h888;
      @(posedge i_clk); #1;
      man_int = 1'b0; i_wb_cyc = 1'b0; i_wb_stb = 1'b0; i_wb_we = 1'b0;
      for (int i = 0; i < 40 && (acc_cnt == n0 || o_aud_cyc); i++) begin
         @(posedge i_clk); #1;
      end
      check_val("stall_accepts", acc_cnt, n0 + 1);
      check_val("stall_word", last_word, 32'h0020_0777);
      check_val("stall_stb_len", last_stb, 32'd5);
      check_val("stall_stable", last_unstable, 32'd0);
      wb_read(1'b0, rd);  check_val("pushpop_fill", rd, 32'd1);
      stall_len = 0;
      pulse_wait("after_stall", 32'h0020_0888);

      // reset in the middle of a transaction
      stall_len = 1000;
      wb_write(1'b0, 32'h999);
      n0 = acc_cnt;
      pulse();
      for (int i = 0; i < 10 && !o_aud_stb; i++) begin
         @(posedge i_clk); #1;
      end
      i_rst = 1'b1;
      @(posedge i_clk); #1;
      i_rst = 1'b0;
      check_val("rst_mid_bus", {30'd0, o_aud_cyc, o_aud_stb}, 32'd0);
      stall_len = 0;
      wb_read(1'b1, rd);  check_val("rst_mid_status", rd, 32'h0000_0010);
      check_val("rst_mid_noacc", acc_cnt, n0);

`ifdef WB_PWMAUDIO_FEEDER_TIMEOUT_EN
      // device never acks: watchdog abandons the transfer
      wb_write(1'b1, 32'h1);
      wb_write(1'b0, 32'h55);
      no_ack = 1'b1;
      pulse();
      cnt = 0;
      while (o_aud_cyc && cnt < 400) begin
         cnt++;
         @(posedge i_clk); #1;
      end
      check_val("timeout_len", {31'd0, (cnt >= 255 && cnt <= 257)}, 32'd1);
      no_ack = 1'b0;
      wb_read(1'b1, rd);  check_val("timeout_err", {31'd0, rd[7]}, 32'd1);
      wb_write(1'b1, 32'h5);
      wb_read(1'b1, rd);  check_val("timeout_clr", {31'd0, rd[7]}, 32'd0);
`endif

      // randomized pushes against random device timing; words must arrive in push order
      wb_write(1'b1, 32'h0010_0001);
      rand_mode = 1'b1; auto_int = 1'b1;
      rx_base = rx_q.size();
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 2) == 0 && (sent_q.size() - (rx_q.size() - rx_base)) < 24) begin
            s = 16'($urandom);
            wb_write(1'b0, {16'h0000, s});
            sent_q.push_back(32'h0010_0000 | {16'h0000, s});
         end else begin
            @(posedge i_clk); #1;
         end
      end
      for (int i = 0; i < 3000 && ((rx_q.size() - rx_base) < sent_q.size() || o_aud_cyc); i++) begin
         @(posedge i_clk); #1;
      end
      auto_int = 1'b0; rand_mode = 1'b0;
      for (int i = 0; i < 20 && o_aud_cyc; i++) begin
         @(posedge i_clk); #1;
      end
      check_val("rand_count", rx_q.size() - rx_base, sent_q.size());
      for (int k = 0; k < sent_q.size() && (rx_base + k) < rx_q.size(); k++)
         check_val("rand_word", rx_q[rx_base + k], sent_q[k]);
      wb_read(1'b0, rd);  check_val("rand_fill", rd, 32'd0);
      check_val("rand_int", {31'd0, o_int}, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/wb_pwmaudio_feeder.md
Name: wb_pwmaudio_feeder

Overview:
- Wishbone-slave sample buffer plus Wishbone-master sequencer that keeps the PWM audio peripheral supplied with samples.
- CPU pushes 16-bit samples into a local FIFO. When the audio device raises its "need sample" interrupt, the block pops one sample and writes it to the device.
- Sits between the CPU bus and the PWM audio slave. It reduces CPU interrupt load from once per sample to once per FIFO low-water event.

Parameters:
- LGFIFO, 5: log2 FIFO depth (32 entries); legal range 2..7.
- LOW_WATER, 8: o_int asserts while fill level <= LOW_WATER.
- NAUX, 2: auxiliary output bits forwarded to the device; legal range 1..4.

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  synchronous, active-high reset
- i_wb_cyc, i_wb_stb, i_wb_we  in  1 each  CPU-side slave strobes
- i_wb_addr  in  1  0 = sample FIFO, 1 = control/status
- i_wb_data  in  32  CPU write data
- o_wb_ack  out  1  slave ack
- o_wb_stall  out  1  slave stall, tied 0
- o_wb_data  out  32  slave read data
- o_aud_cyc, o_aud_stb, o_aud_we  out  1 each  master strobes to audio device; we is always 1
- o_aud_addr  out  1  always 0 (sample register)
- o_aud_data  out  32  sample word to device
- i_aud_ack, i_aud_stall  in  1 each  device handshake
- i_aud_int  in  1  device "next sample empty" level
- o_int  out  1  FIFO low-water interrupt to CPU

Behaviour:
- Reset values:
  - All outputs 0.
  - FIFO empty, FSM IDLE.
  - Control bits 0, aux 0, aux_pending 0.
  - Underrun count 0; overflow and err flags 0.
- Slave interface:
  - o_wb_ack <= i_wb_stb every cycle (ack exactly 1 cycle after stb); o_wb_stall = 0.
  - o_wb_data is registered.
- Write to addr 0: push i_wb_data[15:0]. If FIFO full: drop the sample, set sticky overflow.
- Read from addr 0: {zeros, fill[LGFIFO:0]}.
- Write to addr 1:
  - bit0 = enable.
  - bit1 = flush (one-shot).
  - bit2 = clear underrun count and overflow/err flags (one-shot).
  - bit3 = silence_on_underrun.
  - bits[NAUX+19:20] = aux value.
  - bit16 = 1 sets aux_pending.
- Read from addr 1:
  - [31:24] underrun count; [NAUX+19:20] aux; [16] aux_pending; [15:8] fill.
  - [7] err; [6] busy (FSM not IDLE); [5] full; [4] empty.
  - [3] silence_on_underrun; [2] overflow; [0] enable.
- FIFO simultaneous events:
  - Push and pop in the same cycle: both occur, fill unchanged.
  - Flush plus push in the same cycle: flush wins, push dropped.
  - Flush never affects a sample already popped into o_aud_data.
- o_int = enable && (fill <= LOW_WATER); combinational from registers.
- Master FSM states: IDLE, REQ, WAIT.
  - IDLE -> REQ when enable && i_aud_int && (!empty || silence_on_underrun).
    - Same edge: pop FIFO, or use 16'h0000 if empty.
    - Load o_aud_data = {zeros, aux, 3'b0, aux_pending, sample[15:0]}.
    - Assert o_aud_cyc and o_aud_stb.
  - REQ: hold o_aud_stb and o_aud_data while i_aud_stall. On a cycle with !i_aud_stall the request is accepted: drop stb next edge, go to WAIT.
  - Acceptance clears aux_pending if the word carried bit16. A control write setting aux_pending in the same cycle wins.
  - WAIT: on i_aud_ack, drop o_aud_cyc and return to IDLE. i_aud_ack is ignored outside WAIT.
  - i_aud_int is sampled only in IDLE. Minimum spacing between device writes is 3 cycles.
- Underrun:
  - Trigger: rising edge of i_aud_int (registered previous value) while enable && FIFO empty.
  - Action: increment underrun count, saturating at 255.
  - Applies whether or not silence is enabled.
- Enable cleared mid-transfer: the current transaction completes, then the FSM stays in IDLE.
- i_rst mid-transaction: o_aud_cyc/o_aud_stb are 0 from the next edge and the in-flight sample is discarded.

Optional Feature:
- Macro: WB_PWMAUDIO_FEEDER_TIMEOUT_EN.
- Defined:
  - 8-bit watchdog counts cycles spent in REQ or WAIT; cleared on entry to REQ.
  - On reaching 255: drop cyc/stb, set sticky err, go to IDLE; the sample is lost.
- Undefined: the FSM waits indefinitely in REQ/WAIT and status bit7 reads 0.

Test Plan:
- Reset; write ctrl 0x1; push 0x1234; pulse i_aud_int high → one master write of 0x00001234 with stb for 1 cycle and cyc until ack; fill returns to 0.
- Push 40 samples with LGFIFO=5 → samples 33..40 dropped; status shows full=1, overflow=1, fill=32; o_int=0 until fill <= 8.
- FIFO empty, enable=1, silence=0, i_aud_int rises twice → no master write; underrun count = 2. Set silence=1 → write of 0x00000000 issued.
- Write ctrl with bit16=1, aux=2'b10, enable → next device write data = 0x00210000|sample; the following write has bit16=0 and aux still 2'b10.
- Device holds i_aud_stall for 4 cycles → stb and data stable for 5 cycles; exactly one acceptance; push in the same cycle as pop leaves fill unchanged.
- With WB_PWMAUDIO_FEEDER_TIMEOUT_EN defined, device never acks → cyc drops after 255 cycles and status bit7=1; a ctrl write with bit2 clears it.
